// File: rtl/uart_top.sv
// uart_top: APB-style slave around a full-duplex UART (8 data bits, even parity, 1 stop).
// A write loads the transmitter and stalls with PREADY low while a frame is in flight.
// A read returns the last good received byte.
// There is no address decoding, so one data register serves both directions.
module uart_top #(
   parameter int CLKS_PER_BIT = 2604
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PWDATA,
   input  logic       rxd,
   output logic       PREADY,
   output logic [7:0] PRDATA,
   output logic       txd
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // transmit side
   state_t           tx_state_reg;
   logic [CNT_W-1:0] tx_baud_reg;
   logic [2:0]       tx_bit_reg;
   logic [7:0]       tx_shift_reg;
   logic             tx_parity_reg;
   logic             txd_reg;

   // receive side
   logic             rx_sync1_reg;
   logic             rx_sync2_reg;
   logic             rx_prev_reg;
   state_t           rx_state_reg;
   logic [CNT_W-1:0] rx_baud_reg;
   logic [2:0]       rx_bit_reg;
   logic [7:0]       rx_shift_reg;
   logic             rx_parity_reg;
   logic             frame_ok_reg;
   logic [7:0]       rx_data_reg;

   logic wr_access;
   logic rd_access;
   logic tx_accept;
   logic tx_bit_end;
   logic rx_fall;

   assign wr_access  = PSEL & PENABLE & PWRITE;
   assign rd_access  = PSEL & PENABLE & ~PWRITE;
   assign tx_accept  = wr_access & (tx_state_reg == ST_IDLE);
   assign tx_bit_end = (tx_baud_reg == BIT_LAST);
   // Edge rather than level, so a low stop bit cannot look like a new start.
   assign rx_fall    = rx_prev_reg & ~rx_sync2_reg;

   // Writes stall while the transmitter is busy; reads never wait.
   assign PREADY = rd_access | tx_accept;
   assign PRDATA = rx_data_reg;
   assign txd    = txd_reg;

   // Transmit FSM: each non-idle state lasts exactly one bit-time, txd is registered.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tx_state_reg  <= ST_IDLE;
         tx_baud_reg   <= '0;
         tx_bit_reg    <= '0;
         tx_shift_reg  <= '0;
         tx_parity_reg <= 1'b0;
         txd_reg       <= 1'b1;
      end else begin
         if (tx_state_reg != ST_IDLE)
            tx_baud_reg <= tx_bit_end ? '0 : tx_baud_reg + 1'b1;
         case (tx_state_reg)
            ST_IDLE: begin
               txd_reg <= 1'b1;
               if (tx_accept) begin
                  tx_shift_reg  <= PWDATA;
                  tx_parity_reg <= ^PWDATA;
                  tx_baud_reg   <= '0;
                  txd_reg       <= 1'b0;
                  tx_state_reg  <= ST_START;
               end
            end
            ST_START: begin
               if (tx_bit_end) begin
                  tx_bit_reg   <= '0;
                  txd_reg      <= tx_shift_reg[0];
                  tx_state_reg <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tx_bit_end) begin
                  if (tx_bit_reg == 3'd7) begin
                     txd_reg      <= tx_parity_reg;
                     tx_state_reg <= ST_PARITY;
                  end else begin
                     tx_bit_reg   <= tx_bit_reg + 1'b1;
                     tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                     txd_reg      <= tx_shift_reg[1];
                  end
               end
            end
            ST_PARITY: begin
               if (tx_bit_end) begin
                  txd_reg      <= 1'b1;
                  tx_state_reg <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (tx_bit_end)
                  tx_state_reg <= ST_IDLE;
            end
            default: tx_state_reg <= ST_IDLE;
         endcase
      end
   end

   // Two-flop synchroniser for rxd plus one more stage for falling-edge detection.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         rx_sync1_reg <= 1'b1;
         rx_sync2_reg <= 1'b1;
         rx_prev_reg  <= 1'b1;
      end else begin
         rx_sync1_reg <= rxd;
         rx_sync2_reg <= rx_sync1_reg;
         rx_prev_reg  <= rx_sync2_reg;
      end
   end

   // Receive FSM: confirm start at half a bit, then sample every bit-time (mid-bit).
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         rx_state_reg  <= ST_IDLE;
         rx_baud_reg   <= '0;
         rx_bit_reg    <= '0;
         rx_shift_reg  <= '0;
         rx_parity_reg <= 1'b0;
         frame_ok_reg  <= 1'b0;
      end else begin
         frame_ok_reg <= 1'b0;
         case (rx_state_reg)
            ST_IDLE: begin
               rx_baud_reg <= '0;
               if (rx_fall)
                  rx_state_reg <= ST_START;
            end
            ST_START: begin
               if (rx_baud_reg == HALF_LAST) begin
                  rx_baud_reg  <= '0;
                  rx_bit_reg   <= '0;
                  // A line already back high is a glitch, not a start bit.
                  rx_state_reg <= rx_sync2_reg ? ST_IDLE : ST_DATA;
               end else begin
                  rx_baud_reg <= rx_baud_reg + 1'b1;
               end
            end
            ST_DATA: begin
               if (rx_baud_reg == BIT_LAST) begin
                  rx_baud_reg  <= '0;
                  rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
                  if (rx_bit_reg == 3'd7)
                     rx_state_reg <= ST_PARITY;
                  else
                     rx_bit_reg <= rx_bit_reg + 1'b1;
               end else begin
                  rx_baud_reg <= rx_baud_reg + 1'b1;
               end
            end
            ST_PARITY: begin
               if (rx_baud_reg == BIT_LAST) begin
                  rx_baud_reg   <= '0;
                  rx_parity_reg <= rx_sync2_reg;
                  rx_state_reg  <= ST_STOP;
               end else begin
                  rx_baud_reg <= rx_baud_reg + 1'b1;
               end
            end
            ST_STOP: begin
               if (rx_baud_reg == BIT_LAST) begin
                  rx_baud_reg  <= '0;
                  frame_ok_reg <= rx_sync2_reg & (rx_parity_reg == ^rx_shift_reg);
                  rx_state_reg <= ST_IDLE;
               end else begin
                  rx_baud_reg <= rx_baud_reg + 1'b1;
               end
            end
            default: rx_state_reg <= ST_IDLE;
         endcase
      end
   end

   // Receive holding register: loaded one cycle after a good stop-bit sample.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         rx_data_reg <= 8'h00;
      else if (frame_ok_reg)
         rx_data_reg <= rx_shift_reg;
   end

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: randomized self-checking bench for uart_top.
// The reference model derives txd per cycle from the last accepted byte and its acceptance cycle.
// Write wait states come from the 11-bit frame length.
// PRDATA is predicted from the frames the bench itself sends.
module tb_uart_top;

   localparam int C = 16;

   logic       PCLK;
   logic       PRESET;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PWDATA;
   logic       rxd;
   logic       PREADY;
   logic [7:0] PRDATA;
   logic       txd;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   // reference model state
   int         last_acc = -1;
   logic [7:0] last_byte = 8'h00;
   logic [7:0] exp_rx = 8'h00;
   bit         mon_en = 1'b0;

   uart_top #(.CLKS_PER_BIT(C)) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .rxd     (rxd),
      .PREADY  (PREADY),
      .PRDATA  (PRDATA),
      .txd     (txd)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Frame bit n: 0 start, 1..8 data LSB first, 9 even parity, 10 stop.
   function automatic logic frame_bit(input logic [7:0] b, input int n);
      logic r;
      if (n == 0)
         r = 1'b0;
      else if (n <= 8)
         r = b[n-1];
      else if (n == 9)
         r = ^b;
      else
         r = 1'b1;
      return r;
   endfunction

   function automatic logic exp_txd(input int c);
      int k;
      logic r;
      r = 1'b1;
      if (last_acc >= 0) begin
         k = c - last_acc;
         if (k >= 1 && k <= 11 * C)
            r = frame_bit(last_byte, (k - 1) / C);
      end
      return r;
   endfunction

   // Compare txd against the model in every cycle, away from the clock edge.
   always @(negedge PCLK) begin
      #2;
      if (mon_en)
         check("txd", 32'(txd), 32'(exp_txd(cyc)));
   end

   task automatic apb_write(input logic [7:0] d, input bit with_setup);
      int acc_start;
      int waits;
      int exp_waits;
      @(negedge PCLK);
      PSEL   = 1'b1;
      PWRITE = 1'b1;
      PWDATA = d;
      if (with_setup) begin
         PENABLE = 1'b0;
         #1 check("pready_wr_setup", 32'(PREADY), 32'd0);
         @(negedge PCLK);
      end
      PENABLE   = 1'b1;
      acc_start = cyc;
      waits     = 0;
      #1;
      while (PREADY !== 1'b1 && waits < 20 * C) begin
         @(negedge PCLK);
         #1;
         waits++;
      end
      exp_waits = 0;
      if (last_acc >= 0) begin
         exp_waits = last_acc + 11 * C + 1 - acc_start;
         if (exp_waits < 0)
            exp_waits = 0;
      end
      check("wr_waits", 32'(waits), 32'(exp_waits));
      check("pready_wr", 32'(PREADY), 32'd1);
      last_acc  = cyc;
      last_byte = d;
      $display("APB WR 0x%02h waits=%0d", d, waits);
      @(negedge PCLK);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
   endtask

   task automatic apb_read(input string tag);
      @(negedge PCLK);
      PSEL    = 1'b1;
      PWRITE  = 1'b0;
      PENABLE = 1'b0;
      #1 check("pready_rd_setup", 32'(PREADY), 32'd0);
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1;
      check("pready_rd", 32'(PREADY), 32'd1);
      check(tag, 32'(PRDATA), 32'(exp_rx));
      $display("APB RD 0x%02h", PRDATA);
      @(negedge PCLK);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic [10:0] bits;
      bits = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
      for (int n = 0; n < 11; n++) begin
         @(negedge PCLK);
         rxd = bits[n];
         repeat (C - 1) @(negedge PCLK);
      end
      @(negedge PCLK);
      rxd = 1'b1;
      if (!bad_par && !bad_stop)
         exp_rx = d;
      $display("RX frame 0x%02h par_err=%0d stop_err=%0d", d, bad_par, bad_stop);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tx_b;
      logic [7:0] rx_b;
      bit         bp;
      bit         bs;

      PRESET  = 1'b0;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PWDATA  = 8'h00;
      rxd     = 1'b1;

      // asynchronous reset, no clock edge yet
      #1 PRESET = 1'b1;
      #1;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_pready", 32'(PREADY), 32'd0);
      check("rst_prdata", 32'(PRDATA), 32'd0);
      repeat (2) @(negedge PCLK);
      PRESET = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge PCLK);

      // transmit 0x9D, then a back-to-back 0x55 stalled for a full frame
      apb_write(8'h9D, 1'b1);
      apb_write(8'h55, 1'b0);
      repeat (11 * C + 2) @(negedge PCLK);

      // receive: good frame, parity error, start glitch, frame after glitch
      send_frame(8'hBE, 1'b0, 1'b0);
      apb_read("rd_be");
      send_frame(8'h3C, 1'b1, 1'b0);
      apb_read("rd_par_err");
      @(negedge PCLK);
      rxd = 1'b0;
      repeat (4) @(negedge PCLK);
      rxd = 1'b1;
      repeat (C) @(negedge PCLK);
      apb_read("rd_glitch");
      send_frame(8'h01, 1'b0, 1'b0);
      apb_read("rd_after_glitch");

      // randomized concurrent transmit/receive
      for (int it = 0; it < 8; it++) begin
         tx_b = 8'($urandom);
         rx_b = 8'($urandom);
         bp   = ($urandom_range(0, 3) == 0);
         bs   = ($urandom_range(0, 3) == 0) && !bp;
         fork
            apb_write(tx_b, 1'b1);
            send_frame(rx_b, bp, bs);
         join
         if (it % 3 == 0)
            apb_write(8'($urandom), 1'b0);
         apb_read("rd_rand");
      end
      repeat (11 * C + 2) @(negedge PCLK);

      // reset in the middle of a transmit (txd low) and a receive
      apb_write(8'h5A, 1'b1);
      @(negedge PCLK);
      rxd = 1'b0;
      repeat (3 * C) @(negedge PCLK);
      #3;
      mon_en   = 1'b0;
      last_acc = -1;
      exp_rx   = 8'h00;
      PRESET   = 1'b1;
      #1;
      check("midrst_txd", 32'(txd), 32'd1);
      check("midrst_prdata", 32'(PRDATA), 32'd0);
      check("midrst_pready", 32'(PREADY), 32'd0);
      @(negedge PCLK);
      rxd = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0;
      mon_en = 1'b1;
      repeat (12 * C) @(negedge PCLK);
      apb_read("rd_after_rst");
      send_frame(8'hC3, 1'b0, 1'b0);
      apb_read("rd_final");
      repeat (4) @(negedge PCLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
